// File: rtl/cam_pkg.sv
// Shared types and default sizing for the bit-serial CAM search array.
package cam_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_WORDS = 100;
  localparam int DEF_SLICE = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } cam_state_e;

  // Index width that stays at least one bit wide for degenerate sizes.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cam_match_encoder.sv
// Reduces the per-word mismatch vector to any-match, lowest matching index and match count.
module cam_match_encoder
  import cam_pkg::*;
#(
  parameter  int WORDS = DEF_WORDS,
  localparam int AW    = idx_width(WORDS),
  localparam int CW    = $clog2(WORDS + 1)
) (
  input  logic [WORDS-1:0] mismatch_lines,
  output logic             match_any,
  output logic [AW-1:0]    first_match_addr,
  output logic [CW-1:0]    match_count
);

  // NOTE: every output gets a default before the loop so no path leaves one unassigned (no latch).
  always_comb begin
    match_any        = ~&mismatch_lines;
    first_match_addr = '0;
    match_count      = '0;
    // Walking downwards lets the lowest matching index win.
    for (int i = WORDS - 1; i >= 0; i--) begin
      if (!mismatch_lines[i]) first_match_addr = AW'(i);
      match_count = match_count + CW'(!mismatch_lines[i]);
    end
  end

endmodule

// File: rtl/cam_search_array.sv
// CAM that stores WORDS entries and compares them against a masked key SLICE bits per cycle.
module cam_search_array
  import cam_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int WORDS = DEF_WORDS,
  parameter  int SLICE = DEF_SLICE,
  localparam int AW    = idx_width(WORDS),
  localparam int CW    = $clog2(WORDS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] comparand,
  input  logic [WIDTH-1:0] mask,
  input  logic             perform_search,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             clr_all,
  output logic             busy,
  output logic             done,
  output logic [WORDS-1:0] mismatch_lines,
  output logic             match_any,
  output logic [AW-1:0]    first_match_addr,
  output logic [CW-1:0]    match_count
);

  localparam int N    = WIDTH / SLICE;
  localparam int CNTW = idx_width(N);

  if (WIDTH % SLICE != 0) begin : g_width_check
    $error("cam_search_array: WIDTH must be a multiple of SLICE");
  end

  cam_state_e       state;
  logic [WIDTH-1:0] mem [WORDS];
  logic [WORDS-1:0] valid;
  logic [WORDS-1:0] acc;
  logic [WORDS-1:0] acc_next;
  logic [CNTW-1:0]  cnt;
  logic [WIDTH-1:0] key_q;
  logic [WIDTH-1:0] care_q;
  logic             wr_ok;

  assign wr_ok = wr_en && (32'(wr_addr) < WORDS);

  function automatic logic slice_miss(input logic [WIDTH-1:0] word, key, care, input int k);
    logic [WIDTH-1:0] diff;
    diff = (word ^ key) & care;
    return |diff[k*SLICE +: SLICE];
  endfunction

  always_comb begin
    acc_next = acc;
    for (int i = 0; i < WORDS; i++)
      acc_next[i] = acc[i] | slice_miss(mem[i], key_q, care_q, int'(cnt));
  end

  // NOTE: the data array has no reset; the valid bits alone decide whether a word can match.
  always_ff @(posedge clk) begin
    if (state == IDLE && wr_ok) mem[wr_addr] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      valid          <= '0;
      acc            <= '1;
      cnt            <= '1;
      mismatch_lines <= '1;
      key_q          <= '0;
      care_q         <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          // Clear first; the later bit write overrides it for the written word.
          if (clr_all) valid <= '0;
          if (wr_ok) valid[wr_addr] <= 1'b1;
          if (perform_search) begin
            state  <= SEARCH;
            key_q  <= comparand;
            care_q <= mask;
            cnt    <= '0;
            acc    <= '0;
            busy   <= 1'b1;
          end
        end
        SEARCH: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          if (cnt == CNTW'(N - 1)) begin
            state          <= DONE;
            mismatch_lines <= acc_next | ~valid;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  cam_match_encoder #(.WORDS(WORDS)) u_encoder (
    .mismatch_lines  (mismatch_lines),
    .match_any       (match_any),
    .first_match_addr(first_match_addr),
    .match_count     (match_count)
  );

endmodule
